fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the decode/control stage of the 16-bit CPU.
//  - Owns the fetch PC and issues reads to a synchronous (1-cycle latency) instruction memory.
//  - Buffers returned words with their PC in a small prefetch FIFO.
//  - Presents them to decode over a valid/ready handshake.
//  - Accepts a redirect (branch/jump) that flushes all buffered and in-flight work.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: default widths, the prefetch entry type and
// instruction field positions used by both the fetch and decode/control stages.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_INST_W = 16;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 9;
  localparam int SRCA_MSB = 8;
  localparam int SRCA_LSB = 6;
  localparam int SRCB_MSB = 5;
  localparam int SRCB_LSB = 3;
  localparam int DST_MSB  = 2;
  localparam int DST_LSB  = 0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] inst_opcode(input logic [FETCH_INST_W-1:0] i);
    return i[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} entries; power-of-two depth, flush clears
// pointers and count in one cycle and takes priority over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = FETCH_ADDR_W + FETCH_INST_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        wptr, rptr;
  logic                    do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= (wptr + PTR_W'(1)) & PTR_MASK;
      if (do_pop) rptr <= (rptr + PTR_W'(1)) & PTR_MASK;
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= din;
  end

  assign head = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns fetch PC, issues 1-cycle-latency imem reads
// under a FIFO credit, buffers {pc,inst}, hands off to decode via valid/ready.
// Optional stall counter when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = FETCH_ADDR_W,
  parameter int               INST_W   = FETCH_INST_W,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_starve_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc, tag_pc;
  logic              inflight;
  logic              credit;
  logic              push, pop, flush;
  logic [CNT_W-1:0]  count;
  entry_t            push_entry, head_entry;

  // In-flight request reserves a slot; a same-cycle pop is deliberately not credited.
  assign credit    = (int'(count) + int'(inflight)) < DEPTH;
  assign imem_req  = !rst && !redirect_valid && credit;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        tag_pc   <= fetch_pc;
      end
    end
  end

  assign push  = inflight && !redirect_valid && !rst;
  assign pop   = inst_valid && inst_ready;
  assign flush = rst || redirect_valid;

  assign push_entry.pc   = tag_pc;
  assign push_entry.inst = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .count (count),
    .head  (head_entry)
  );

  assign inst_valid = (count != '0);
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      perf_starve_cnt <= '0;
    else if (inst_ready && !inst_valid && (perf_starve_cnt != 16'hFFFF))
      perf_starve_cnt <= perf_starve_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected {pc,inst}
// into a queue, a negedge monitor pops and compares on every handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_starve_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] inst;
  } exp_t;
  exp_t exp_q[$];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // Synchronous instruction memory, 1-cycle read latency.
  always @(posedge clk) if (imem_req) imem_rdata <= mem_f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_range(input logic [7:0] first, input int n);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = first + 8'(i);
      exp_q.push_back('{p, mem_f(p)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual_pc=%h required=none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", 32'(inst_pc), 32'(e.pc));
        chk("pop_inst", 32'(inst), 32'(e.inst));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nreq;
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
    exp_range(8'h00, 6);

    // Reset for two edges
    tick();
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    tick();
    rst = 1'b0;

    // Streaming from RESET_PC: cycles 0..7
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stream_addr", 32'(imem_addr), 32'(k));
      chk("stream_req", 32'(imem_req), 32'd1);
      chk("stream_valid", 32'(inst_valid), (k < 2) ? 32'd0 : 32'd1);
`ifdef FETCH_PERF_CNT_EN
      if (k == 2 || k == 7) chk("perf_first", 32'(perf_starve_cnt), 32'd2);
`endif
      tick();
    end

    // Redirect to 0x10 with decode stalled, then 10 cycles of backpressure
    redirect_valid = 1'b1; redirect_pc = 8'h10; inst_ready = 1'b0;
    @(negedge clk);
    chk("redir_req_low", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    nreq = 0;
    for (int k = 9; k < 19; k++) begin
      @(negedge clk);
      if (imem_req) nreq++;
      if (k == 9) begin
        chk("bp_addr", 32'(imem_addr), 32'h10);
        chk("bp_valid0", 32'(inst_valid), 32'd0);
      end
      if (k >= 11) begin
        chk("bp_hold_valid", 32'(inst_valid), 32'd1);
        chk("bp_hold_pc", 32'(inst_pc), 32'h10);
        chk("bp_hold_inst", 32'(inst), 32'(mem_f(8'h10)));
      end
      if (k == 18) chk("bp_full_req", 32'(imem_req), 32'd0);
      tick();
    end
    chk("bp_nreq", 32'(nreq), 32'd4);

    // Resume: 0x10..0x13, then redirect with a pop in the same cycle (0x14)
    exp_range(8'h10, 5);
    inst_ready = 1'b1;
    for (int k = 19; k < 23; k++) begin
      @(negedge clk);
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    tick();
    redirect_valid = 1'b0;
    exp_range(8'h40, 3);
    @(negedge clk);
    chk("redir_valid0", 32'(inst_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'h40);
    chk("redir_req", 32'(imem_req), 32'd1);
    tick();
    @(negedge clk);
    chk("redir_valid1", 32'(inst_valid), 32'd0);
    tick();
    for (int k = 26; k < 29; k++) begin
      @(negedge clk);
      tick();
    end

    // Wrap across 8'hFF
    redirect_valid = 1'b1; redirect_pc = 8'hFE; inst_ready = 1'b0;
    @(negedge clk);
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    exp_range(8'hFE, 4);
    @(negedge clk);
    chk("wrap_addr", 32'(imem_addr), 32'hFE);
    chk("wrap_valid0", 32'(inst_valid), 32'd0);
    tick();
    for (int k = 31; k < 36; k++) begin
      @(negedge clk);
      tick();
    end

    // Fill the FIFO, then reset mid-stream
    inst_ready = 1'b0;
    for (int k = 36; k < 42; k++) begin
      @(negedge clk);
      if (k == 41) begin
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_valid", 32'(inst_valid), 32'd1);
      end
      tick();
    end
    rst = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    tick();
    rst = 1'b0;
    exp_range(8'h00, 3);
    @(negedge clk);
    chk("post_rst_valid0", 32'(inst_valid), 32'd0);
    chk("post_rst_addr", 32'(imem_addr), 32'h00);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    tick();
    @(negedge clk);
    chk("post_rst_valid1", 32'(inst_valid), 32'd0);
    tick();
    for (int k = 45; k < 48; k++) begin
      @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
      if (k == 45) chk("perf_after_rst", 32'(perf_starve_cnt), 32'd2);
`endif
      tick();
    end
    inst_ready = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
